// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small program memory plus a FETCH/VALID handshake
// that issues a bounded run of instructions at controller-supplied addresses.
module instr_fetch #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [19:0] prog_data,
  input  logic        run,
  input  logic [4:0]  run_len,
  input  logic        halt,
  input  logic [3:0]  address,
  input  logic        instr_ack,
  output logic [3:0]  opcode,
  output logic [7:0]  operand_a,
  output logic [7:0]  operand_b,
  output logic        op,
  output logic        busy,
  output logic        done,
  output logic        prog_err,
  output logic [4:0]  issued
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned IW  = 20;
  localparam int unsigned OPW = 4;
  localparam int unsigned DW  = 8;

  typedef enum logic [1:0] {IDLE, FETCH, VALID, FINISH} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   mem [DEPTH];
  logic [LW-1:0]   len;
  logic [LW-1:0]   len_sat;
  logic            start;
  logic            accept;
  logic            last;

  assign len_sat = (run_len > LW'(DEPTH)) ? LW'(DEPTH) : run_len;
  assign start   = (state == IDLE) && run;
  assign accept  = (state == VALID) && instr_ack;
  assign last    = (issued + LW'(1)) == len;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; halt overrides every non-idle transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = (run_len == '0) ? FINISH : FETCH;
      FETCH:   state_next = VALID;
      VALID:   if (instr_ack) state_next = last ? FINISH : FETCH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (halt && (state != IDLE)) state_next = IDLE;
  end

  // Program memory, presented instruction, run bookkeeping and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
      len       <= '0;
      issued    <= '0;
      opcode    <= '0;
      operand_a <= '0;
      operand_b <= '0;
      op        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      if ((state == IDLE) && prog_we) mem[prog_addr] <= prog_data;
      prog_err <= prog_we && (state != IDLE);
      done     <= (state == FINISH) && !halt;
      op       <= state_next == VALID;
      busy     <= state_next != IDLE;
      if (start) begin
        len    <= len_sat;
        issued <= '0;
      end
      if (accept) issued <= issued + LW'(1);
      if ((state == FETCH) && !halt) begin
        opcode    <= mem[address][IW-1 -: OPW];
        operand_b <= mem[address][2*DW-1 -: DW];
        operand_a <= mem[address][DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed runs checked against a
// behavioural issue model every cycle plus hand-computed literal expectations.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [19:0] prog_data;
  logic        run;
  logic [4:0]  run_len;
  logic        halt;
  logic [3:0]  address;
  logic        instr_ack;
  logic [3:0]  opcode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        op;
  logic        busy;
  logic        done;
  logic        prog_err;
  logic [4:0]  issued;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .run_len(run_len), .halt(halt),
    .address(address), .instr_ack(instr_ack), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .op(op), .busy(busy),
    .done(done), .prog_err(prog_err), .issued(issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is "waiting to fetch", "presenting" or "finishing"
  logic [19:0] m_mem [16];
  logic [19:0] m_word;
  logic [4:0]  m_issued, m_len;
  bit          m_fetch, m_show, m_fin, m_done, m_err, m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_word = '0; m_issued = '0; m_len = '0;
      m_fetch = 0; m_show = 0; m_fin = 0; m_done = 0; m_err = 0;
    end else begin
      m_busy = m_fetch || m_show || m_fin;
      m_err  = prog_we && m_busy;
      m_done = m_fin && !halt;
      if (!m_busy) begin
        if (prog_we) m_mem[prog_addr] = prog_data;
        if (run) begin
          m_issued = '0;
          m_len = (run_len > 5'd16) ? 5'd16 : run_len;
          if (m_len == 5'd0) m_fin = 1; else m_fetch = 1;
        end
      end else if (halt) begin
        if (m_show && instr_ack) m_issued = m_issued + 5'd1;
        m_fetch = 0; m_show = 0; m_fin = 0;
      end else if (m_fetch) begin
        m_word = m_mem[address];
        m_fetch = 0; m_show = 1;
      end else if (m_show) begin
        if (instr_ack) begin
          m_issued = m_issued + 5'd1;
          m_show = 0;
          if (m_issued == m_len) m_fin = 1; else m_fetch = 1;
        end
      end else begin
        m_fin = 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("op",       32'(op),       32'(m_show));
    chk("busy",     32'(busy),     32'(m_fetch || m_show || m_fin));
    chk("done",     32'(done),     32'(m_done));
    chk("prog_err", 32'(prog_err), 32'(m_err));
    chk("issued",   32'(issued),   32'(m_issued));
    chk("word",     32'({opcode, operand_b, operand_a}), 32'(m_word));
  end

  function automatic logic [19:0] expw(input logic [3:0] a);
    logic [7:0] x;
    x = {4'h0, a};
    return {a, 8'(x * 8'd3), x ^ 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [19:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start(input logic [4:0] n, input logic [3:0] a);
    address = a; run = 1'b1; run_len = n;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_op();
    int k = 0;
    while (!op && k < 10) begin
      tick();
      k++;
    end
    chk("op_timeout", 32'(op), 32'd1);
  endtask

  task automatic ack();
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    address = address + 4'd1;
  endtask

  function automatic logic [19:0] word();
    return {opcode, operand_b, operand_a};
  endfunction

  initial begin
    reset = 1'b1;
    prog_we = 0; prog_addr = 0; prog_data = 0; run = 0; run_len = 0;
    halt = 0; address = 0; instr_ack = 0;
    tick(); tick();
    chk("rst_op", 32'(op), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_issued", 32'(issued), 0); chk("rst_word", 32'(word()), 0);
    reset = 1'b0;
    tick();

    // Two-instruction run with address advance
    prog(4'd0, 20'h00503);
    prog(4'd1, 20'h20107);
    start(5'd2, 4'd0);
    chk("r2_fetch_op", 32'(op), 0);
    tick();
    chk("r2_op1", 32'(op), 1); chk("r2_w1", 32'(word()), 32'h00503);
    ack();
    tick();
    chk("r2_op2", 32'(op), 1); chk("r2_w2", 32'(word()), 32'h20107);
    ack();
    chk("r2_finish_busy", 32'(busy), 1); chk("r2_finish_done", 32'(done), 0);
    tick();
    chk("r2_done", 32'(done), 1); chk("r2_issued", 32'(issued), 2);
    tick();
    chk("r2_done_off", 32'(done), 0);

    // Stall in VALID; a run pulse while busy is ignored
    start(5'd1, 4'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin run = 1'b1; run_len = 5'd5; end
      tick();
      run = 1'b0;
      chk("stall_op", 32'(op), 1); chk("stall_w", 32'(word()), 32'h00503);
    end
    ack();
    chk("stall_op_off", 32'(op), 0);
    tick();
    chk("stall_done", 32'(done), 1); chk("stall_issued", 32'(issued), 1);

    // Ack in IDLE is ignored; zero-length run
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
    chk("idle_ack", 32'(issued), 1);
    start(5'd0, 4'd0);
    chk("z_busy", 32'(busy), 1); chk("z_op", 32'(op), 0); chk("z_done0", 32'(done), 0);
    tick();
    chk("z_done", 32'(done), 1); chk("z_issued", 32'(issued), 0);
    tick();

    // Write and run in the same cycle: first fetch sees the new word
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 20'h5AA55;
    start(5'd1, 4'd5);
    prog_we = 1'b0;
    tick();
    chk("wr_run_w", 32'(word()), 32'h5AA55);
    ack(); tick();

    // Rejected write during a run
    prog(4'd3, 20'h33333);
    start(5'd1, 4'd0);
    prog(4'd3, 20'hFFFFF);
    chk("perr_pulse", 32'(prog_err), 1);
    ack();
    chk("perr_off", 32'(prog_err), 0);
    tick();
    start(5'd1, 4'd3);
    tick();
    chk("perr_mem3", 32'(word()), 32'h33333);
    ack(); tick();

    // Saturated length (20 -> 16) with address wrap from 14
    for (int i = 0; i < 16; i++) prog(4'(i), expw(4'(i)));
    start(5'd20, 4'd14);
    for (int n = 0; n < 16; n++) begin
      wait_op();
      chk("wrap_w", 32'(word()), 32'(expw(address)));
      ack();
    end
    tick();
    chk("wrap_done", 32'(done), 1); chk("wrap_issued", 32'(issued), 16);
    tick();

    // Halt in VALID after one ack
    start(5'd4, 4'd0);
    wait_op(); ack(); wait_op();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_op", 32'(op), 0); chk("halt_busy", 32'(busy), 0);
    chk("halt_issued", 32'(issued), 1);
    tick();
    chk("halt_nodone", 32'(done), 0);

    // Halt and ack together: abort but still count
    start(5'd4, 4'd0);
    wait_op();
    halt = 1'b1; instr_ack = 1'b1; tick(); halt = 1'b0; instr_ack = 1'b0;
    chk("ha_issued", 32'(issued), 1); chk("ha_busy", 32'(busy), 0);
    tick();

    // Reset mid-run clears outputs and memory
    start(5'd3, 4'd0);
    ack();
    tick();
    chk("pre_rst_op", 32'(op), 1);
    reset = 1'b1;
    #1;
    chk("mrst_op", 32'(op), 0); chk("mrst_busy", 32'(busy), 0);
    chk("mrst_issued", 32'(issued), 0); chk("mrst_word", 32'(word()), 0);
    tick();
    reset = 1'b0;
    tick();
    start(5'd1, 4'd0);
    tick();
    chk("mrst_mem0", 32'(word()), 0);
    ack(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of program memory words (address width 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port prog_we  input  1  program memory write strobe.
REQ-005 SHALL have port prog_addr  input  4  program memory write address.
REQ-006 SHALL have port prog_data  input  20  instruction word, laid out as [19:16] opcode, [15:8] operand B, [7:0] operand A.
REQ-007 SHALL have port run  input  1  start pulse.
REQ-008 SHALL have port run_len  input  5  number of instructions to issue, 0..16, sampled with run.
REQ-009 SHALL have port halt  input  1  synchronous abort.
REQ-010 SHALL have port address  input  4  program counter driven by the downstream controller.
REQ-011 SHALL have port instr_ack  input  1  consumer accepted the presented instruction this cycle.
REQ-012 SHALL have port opcode  output  4  presented opcode, registered.
REQ-013 SHALL have port operand_a  output  8  presented operand A, registered.
REQ-014 SHALL have port operand_b  output  8  presented operand B, registered.
REQ-015 SHALL have port op  output  1  instruction valid.
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-018 SHALL have port prog_err  output  1  one-cycle pulse on a rejected program write.
REQ-019 SHALL have port issued  output  5  instructions accepted in the current or last run.

Function
REQ-020 SHALL implement a 4-state FSM: IDLE, FETCH, VALID, FINISH.
REQ-021 In IDLE with prog_we=1, SHALL write prog_data to mem[prog_addr] at the clock edge.
REQ-022 In IDLE with run=1 and run_len>0, SHALL latch run_len, clear issued, and go to FETCH.
REQ-023 In IDLE with run=1 and run_len=0, SHALL clear issued and go to FINISH without asserting op.
REQ-024 When prog_we and run occur in the same IDLE cycle, SHALL perform both; the first fetch SHALL observe the newly written word.
REQ-025 FETCH SHALL last exactly one cycle: it registers mem[address] onto opcode/operand_b/operand_a and goes to VALID.
REQ-026 In VALID, op SHALL be 1, and the opcode/operand outputs SHALL hold stable until ack.
REQ-027 In VALID with instr_ack=1, SHALL increment issued; if issued+1 equals the latched length, SHALL go to FINISH, else to FETCH.
REQ-028 The next FETCH after an ack SHALL read the controller-advanced address; address wrap 15->0 is normal and not an error.
REQ-029 instr_ack outside VALID SHALL be ignored.
REQ-030 FINISH SHALL assert done for exactly one cycle, then go to IDLE.
REQ-031 busy SHALL be 1 in FETCH, VALID and FINISH, and 0 in IDLE.
REQ-032 prog_we while busy SHALL NOT modify memory and SHALL pulse prog_err the next cycle.
REQ-033 run while busy SHALL be ignored.
REQ-034 halt in any non-IDLE state SHALL go to IDLE next cycle with op=0 and no done pulse; issued SHALL retain its value.
REQ-035 halt and instr_ack in the same VALID cycle: halt SHALL win, and issued SHALL still increment.
REQ-036 run_len values greater than 16 SHALL be saturated to 16.
REQ-037 Throughput SHALL be at most one instruction per 2 cycles (FETCH+VALID); op latency from run SHALL be 2 cycles.

Reset
REQ-038 On reset: state IDLE, op=0, busy=0, done=0, prog_err=0, issued=0, opcode/operands=0, all memory words=0.
REQ-039 Reset mid-run SHALL abort immediately with no done pulse, and memory SHALL be cleared.

Verification
REQ-040 Load mem[0]=0x0_05_03 and mem[1]=0x2_01_07, then run with run_len=2 and ack each VALID while advancing address -> op shows opcode 0/B 05/A 03, then opcode 2/B 01/A 07; done pulses once; issued=2.
REQ-041 Hold instr_ack=0 for 5 cycles in VALID -> op stays 1 and outputs stay unchanged; ack on cycle 6 -> progresses.
REQ-042 Run with run_len=0 -> done 2 cycles after run; op never asserted; issued=0.
REQ-043 prog_we to addr 3 during a run -> prog_err pulses; mem[3] is unchanged on readback in a later run.
REQ-044 Run with run_len=16, address starting at 14 -> fetches addresses 14, 15, 0, ..., 13; done once; issued=16.
REQ-045 halt in VALID after 1 ack of a run_len=4 run -> IDLE next cycle; op=0; no done; issued=1; reset mid-run -> all outputs 0.
